// File: rtl/m_cp0_exc_pkg.sv
// Shared CP0 constants: register numbers, exception codes and SR/Cause field positions.
package m_cp0_exc_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IE        = 0;
  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;

  function automatic logic [31:0] pack_sr(logic [5:0] im, logic exl, logic ie);
    logic [31:0] v;
    v                     = '0;
    v[SR_IM_LO +: 6]      = im;
    v[SR_EXL]             = exl;
    v[SR_IE]              = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(logic bd, logic [5:0] ip, logic [4:0] code);
    logic [31:0] v;
    v                     = '0;
    v[CAUSE_BD]           = bd;
    v[CAUSE_IP_LO +: 6]   = ip;
    v[CAUSE_EXC_LO +: 5]  = code;
    return v;
  endfunction

endpackage

// File: rtl/m_cp0_arb.sv
// Combinational interrupt/exception arbitration; interrupts win over synchronous exceptions.
module m_cp0_arb
  import m_cp0_exc_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code,
  output logic       req,
  output logic [4:0] code
);

  logic int_req;
  logic exc_req;

  always_comb begin
    int_req = (|(hw_int & im)) & ie & ~exl;
    exc_req = (exc_code != EXC_INT) & ~exl;
    req     = int_req | exc_req;
    code    = int_req ? EXC_INT : exc_code;
  end

endmodule

// File: rtl/m_cp0_exc.sv
// M-stage CP0 exception unit: holds SR/Cause/EPC, serves mfc0/mtc0/eret, raises flush/redirect.
module m_cp0_exc
  import m_cp0_exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] SR_RESET     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic [4:0]  exc_code_i,
  input  logic        bd_i,
  input  logic [5:0]  hw_int_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_addr_i,
  input  logic [31:0] cp0_wd_i,
  input  logic        eret_i,
  output logic [31:0] cp0_rd_o,
  output logic [31:0] epc_o,
  output logic        req_o,
  output logic [31:0] handler_o
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q, epc_d;

  logic        arb_req;
  logic [4:0]  arb_code;
  logic        req;
  logic        unused_wd;

  assign unused_wd = ^{cp0_wd_i[31:16], cp0_wd_i[9:2]};

  m_cp0_arb u_arb (
    .hw_int   (hw_int_i),
    .im       (sr_im_q),
    .ie       (sr_ie_q),
    .exl      (sr_exl_q),
    .exc_code (exc_code_i),
    .req      (arb_req),
    .code     (arb_code)
  );

  // Held low during reset even if SR_RESET would otherwise allow a request.
  assign req       = arb_req & ~reset;
  assign req_o     = req;
  assign epc_o     = epc_q;
  assign handler_o = HANDLER_ADDR;

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = hw_int_i;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (req) begin
      // The faulting instruction is flushed, so its mtc0/eret never happen.
      sr_exl_d    = 1'b1;
      cause_bd_d  = bd_i;
      cause_exc_d = arb_code;
      epc_d       = bd_i ? pc_i - 32'd4 : pc_i;
    end else begin
      if (cp0_we_i) begin
        case (cp0_addr_i)
          CP0_SR: begin
            sr_im_d  = cp0_wd_i[SR_IM_LO +: 6];
            sr_exl_d = cp0_wd_i[SR_EXL];
            sr_ie_d  = cp0_wd_i[SR_IE];
          end
          CP0_EPC: epc_d = cp0_wd_i;
          default: ;
        endcase
      end
      if (eret_i) sr_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= SR_RESET[SR_IM_LO +: 6];
      sr_exl_q    <= SR_RESET[SR_EXL];
      sr_ie_q     <= SR_RESET[SR_IE];
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    cp0_rd_o = 32'd0;
    if (!reset) begin
      case (cp0_addr_i)
        CP0_SR:    cp0_rd_o = pack_sr(sr_im_q, sr_exl_q, sr_ie_q);
        CP0_CAUSE: cp0_rd_o = pack_cause(cause_bd_q, cause_ip_q, cause_exc_q);
        CP0_EPC:   cp0_rd_o = epc_q;
        default:   cp0_rd_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_m_cp0_exc.sv
// Directed self-checking bench for m_cp0_exc with hand-computed expected values.
module tb_m_cp0_exc;

  logic        clk;
  logic        reset;
  logic [31:0] pc_i;
  logic [4:0]  exc_code_i;
  logic        bd_i;
  logic [5:0]  hw_int_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_addr_i;
  logic [31:0] cp0_wd_i;
  logic        eret_i;
  logic [31:0] cp0_rd_o;
  logic [31:0] epc_o;
  logic        req_o;
  logic [31:0] handler_o;

  int total = 0;
  int bad   = 0;

  m_cp0_exc dut (
    .clk        (clk),
    .reset      (reset),
    .pc_i       (pc_i),
    .exc_code_i (exc_code_i),
    .bd_i       (bd_i),
    .hw_int_i   (hw_int_i),
    .cp0_we_i   (cp0_we_i),
    .cp0_addr_i (cp0_addr_i),
    .cp0_wd_i   (cp0_wd_i),
    .eret_i     (eret_i),
    .cp0_rd_o   (cp0_rd_o),
    .epc_o      (epc_o),
    .req_o      (req_o),
    .handler_o  (handler_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    cp0_addr_i = a;
    #1;
    chk(tag, cp0_rd_o, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we_i = 1'b1; cp0_addr_i = a; cp0_wd_i = d;
    step();
    cp0_we_i = 1'b0;
  endtask

  task automatic eret();
    eret_i = 1'b1;
    step();
    eret_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pc_i = '0; exc_code_i = '0; bd_i = 1'b0; hw_int_i = '0;
    cp0_we_i = 1'b0; cp0_addr_i = '0; cp0_wd_i = '0; eret_i = 1'b0;
    exc_code_i = 5'd12;
    step(); #1;
    chk("req_in_reset", {31'd0, req_o}, 32'd0);
    chk("handler", handler_o, 32'h0000_4180);
    exc_code_i = 5'd0;
    reset = 1'b0;
    step();
    rd(5'd12, "sr_after_reset", 32'd0);

    // 1. mid-run async reset
    mtc0(5'd12, 32'hFFFF_FC03);
    rd(5'd12, "sr_write_mask", 32'h0000_FC03);
    hw_int_i = 6'b000001; #1;
    chk("req_masked_exl", {31'd0, req_o}, 32'd0);
    #1 reset = 1'b1; #1;
    rd(5'd12, "sr_async_reset", 32'd0);
    chk("req_async_reset", {31'd0, req_o}, 32'd0);
    chk("epc_async_reset", epc_o, 32'd0);
    step();
    hw_int_i = '0; reset = 1'b0;
    step();
    rd(5'd13, "cause_after_reset", 32'd0);

    // 2. interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    hw_int_i = 6'b000001; pc_i = 32'h0000_1000; #1;
    chk("int_req", {31'd0, req_o}, 32'd1);
    step();
    rd(5'd13, "int_cause", 32'h0000_0400);
    rd(5'd12, "int_sr_exl", 32'h0000_0403);
    chk("int_epc", epc_o, 32'h0000_1000);
    chk("int_no_nest", {31'd0, req_o}, 32'd0);
    hw_int_i = '0;
    eret();
    rd(5'd12, "eret_sr", 32'h0000_0401);

    // 3. Ov in delay slot
    exc_code_i = 5'd12; pc_i = 32'h0000_3010; bd_i = 1'b1; #1;
    chk("ov_req", {31'd0, req_o}, 32'd1);
    step();
    exc_code_i = '0; bd_i = 1'b0;
    chk("ov_epc", epc_o, 32'h0000_300C);
    rd(5'd13, "ov_cause", 32'h8000_0030);
    eret();

    // 4. int beats exc, then nested exc masked
    hw_int_i = 6'b000001; exc_code_i = 5'd12; pc_i = 32'h0000_2000; #1;
    chk("both_req", {31'd0, req_o}, 32'd1);
    step();
    rd(5'd13, "both_cause", 32'h0000_0400);
    hw_int_i = '0; exc_code_i = 5'd5; pc_i = 32'h0000_2200; #1;
    chk("nested_req", {31'd0, req_o}, 32'd0);
    step();
    exc_code_i = '0;
    chk("nested_epc", epc_o, 32'h0000_2000);
    rd(5'd13, "nested_cause", 32'd0);
    eret();

    // 5. mtc0 dropped under req, then retried
    exc_code_i = 5'd4; pc_i = 32'h0000_2400; #1;
    chk("drop_req", {31'd0, req_o}, 32'd1);
    mtc0(5'd14, 32'h0000_3100);
    exc_code_i = '0;
    rd(5'd14, "drop_epc", 32'h0000_2400);
    rd(5'd13, "adel_cause", 32'h0000_0010);
    mtc0(5'd14, 32'h0000_3100);
    rd(5'd14, "retry_epc", 32'h0000_3100);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, "cause_ro", 32'h0000_0010);
    rd(5'd15, "unmapped_rd", 32'd0);

    // 6. eret releases a pending masked interrupt
    hw_int_i = 6'b000001; pc_i = 32'h0000_2800; #1;
    chk("pend_masked", {31'd0, req_o}, 32'd0);
    eret_i = 1'b1; #1;
    chk("pend_eret_cyc", {31'd0, req_o}, 32'd0);
    step();
    eret_i = 1'b0; #1;
    chk("pend_taken", {31'd0, req_o}, 32'd1);
    step();
    hw_int_i = '0;
    chk("pend_epc", epc_o, 32'h0000_2800);
    rd(5'd12, "pend_sr", 32'h0000_0403);

    // mtc0 SR with eret: write applied then EXL cleared
    cp0_we_i = 1'b1; cp0_addr_i = 5'd12; cp0_wd_i = 32'h0000_0C03; eret_i = 1'b1;
    step();
    cp0_we_i = 1'b0; eret_i = 1'b0;
    rd(5'd12, "mtc0_eret_sr", 32'h0000_0C01);

    // EPC wrap for pc=0 in delay slot
    exc_code_i = 5'd10; pc_i = 32'd0; bd_i = 1'b1;
    step();
    exc_code_i = '0; bd_i = 1'b0;
    chk("epc_wrap", epc_o, 32'hFFFF_FFFC);
    rd(5'd13, "ri_cause", 32'h8000_0028);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
